// File: rtl/gpu_pkg.sv
// Shared defaults, register-index split helpers and the read tag type for the
// banked register file arbiter.
package gpu_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_NUM_BANKS = 4;
  localparam int unsigned DEF_REG_W     = 8;
  localparam int unsigned DEF_DATA_W    = 64;
  localparam int unsigned DEF_BANK_LAT  = 1;

  localparam int unsigned TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Low index bits select the bank, upper bits the row within it.
  function automatic int unsigned reg_bank(input int unsigned reg_idx,
                                           input int unsigned num_banks);
    return reg_idx % num_banks;
  endfunction

  function automatic int unsigned reg_row(input int unsigned reg_idx,
                                          input int unsigned num_banks);
    return reg_idx / num_banks;
  endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// Round-robin arbiter for one bank: first request at or after the pointer
// wins, and the pointer moves just past the winner.
module gpu_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    grant     = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + off) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid  = 1'b1;
        gnt_id     = IW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gpu_bank_arbiter.sv
// Register file bank arbiter: writeback wins its bank, reads are granted
// round-robin per bank, and read data is routed back via a tag pipeline.
module gpu_bank_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter int unsigned REG_W     = DEF_REG_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BANK_LAT  = DEF_BANK_LAT
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_REQ-1:0]                             req_valid,
  input  logic [NUM_REQ*REG_W-1:0]                       req_reg,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic                                           wb_valid,
  input  logic [REG_W-1:0]                               wb_reg,
  input  logic [DATA_W-1:0]                              wb_data,
  output logic [NUM_BANKS-1:0]                           bank_rd_en,
  output logic [NUM_BANKS-1:0]                           bank_wr_en,
  output logic [NUM_BANKS*(REG_W-$clog2(NUM_BANKS))-1:0] bank_addr,
  output logic [DATA_W-1:0]                              bank_wr_data,
  input  logic [NUM_BANKS*DATA_W-1:0]                    bank_rd_data,
  output logic [NUM_REQ-1:0]                             rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]                      rsp_data,
  output logic [15:0]                                    conflict_cnt
);

  localparam int unsigned BW    = $clog2(NUM_BANKS);
  localparam int unsigned ROW_W = REG_W - BW;
  localparam int unsigned IW    = $clog2(NUM_REQ);

  logic [BW-1:0]        rq_bank [NUM_REQ];
  logic [ROW_W-1:0]     rq_row  [NUM_REQ];
  logic [BW-1:0]        wb_bank;
  logic [ROW_W-1:0]     wb_row;
  logic [NUM_BANKS-1:0] wb_hit;
  logic [NUM_REQ-1:0]   bank_req [NUM_BANKS];
  logic [NUM_REQ-1:0]   grant    [NUM_BANKS];
  logic [NUM_BANKS-1:0] gnt_valid;
  logic [IW-1:0]        gnt_id   [NUM_BANKS];
  logic                 conflict_hit;

  logic [NUM_BANKS-1:0] rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ROW_W-1:0]     addr_q [NUM_BANKS];
  logic [ROW_W-1:0]     addr_d [NUM_BANKS];
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  tag_t                 tag_q [BANK_LAT+1][NUM_BANKS];
  tag_t                 tag_d [BANK_LAT+1][NUM_BANKS];
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q [NUM_REQ];
  logic [DATA_W-1:0]    rsp_data_d [NUM_REQ];
  logic [15:0]          cnt_q, cnt_d;

  always_comb begin
    wb_bank = BW'(reg_bank(32'(wb_reg), NUM_BANKS));
    wb_row  = ROW_W'(reg_row(32'(wb_reg), NUM_BANKS));
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rq_bank[i] = BW'(reg_bank(32'(req_reg[i*REG_W +: REG_W]), NUM_BANKS));
      rq_row[i]  = ROW_W'(reg_row(32'(req_reg[i*REG_W +: REG_W]), NUM_BANKS));
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      wb_hit[b]   = wb_valid && (wb_bank == BW'(b));
      bank_req[b] = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        bank_req[b][i] = req_valid[i] && (rq_bank[i] == BW'(b)) && !wb_hit[b];
      end
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    gpu_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (bank_req[gb]),
      .grant     (grant[gb]),
      .gnt_valid (gnt_valid[gb]),
      .gnt_id    (gnt_id[gb])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      req_ready = req_ready | grant[b];
    end
    conflict_hit = |(req_valid & ~req_ready);
  end

  // A bank never sees both a write and a read: the write already masked reads.
  always_comb begin
    rd_en_d   = gnt_valid;
    wr_en_d   = wb_hit;
    wr_data_d = wb_valid ? wb_data : '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      addr_d[b] = '0;
      if (wb_hit[b]) begin
        addr_d[b] = wb_row;
      end else if (gnt_valid[b]) begin
        addr_d[b] = rq_row[gnt_id[b]];
      end
      tag_d[0][b].valid = gnt_valid[b];
      tag_d[0][b].id    = TAG_ID_W'(gnt_id[b]);
    end
    for (int unsigned s = 1; s <= BANK_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // The last tag stage lines up with bank_rd_data for its bank.
  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_data_d[i] = '0;
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (tag_q[BANK_LAT][b].valid && tag_q[BANK_LAT][b].id == TAG_ID_W'(i)) begin
          rsp_valid_d[i] = 1'b1;
          rsp_data_d[i]  = bank_rd_data[b*DATA_W +: DATA_W];
        end
      end
    end
    cnt_d = (conflict_hit && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q     <= '0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= '0;
      cnt_q       <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        addr_q[b] <= '0;
        for (int unsigned s = 0; s <= BANK_LAT; s++) begin
          tag_q[s][b] <= '0;
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    bank_rd_en   = rd_en_q;
    bank_wr_en   = wr_en_q;
    bank_wr_data = wr_data_q;
    rsp_valid    = rsp_valid_q;
    conflict_cnt = cnt_q;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_addr[b*ROW_W +: ROW_W] = addr_q[b];
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_data[i*DATA_W +: DATA_W] = rsp_data_q[i];
    end
  end

endmodule

// File: tb/tb_gpu_bank_arbiter.sv
// Directed bench for gpu_bank_arbiter with a behavioural bank model and a
// per-requester response scoreboard.
module tb_gpu_bank_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned NB   = 4;
  localparam int unsigned RW   = 8;
  localparam int unsigned DW   = 64;
  localparam int unsigned LAT  = 1;
  localparam int unsigned ROWW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [RW-1:0]     rr [NR];
  logic [NR*RW-1:0]  req_reg;
  logic [NR-1:0]     req_ready;
  logic              wb_valid;
  logic [RW-1:0]     wb_reg;
  logic [DW-1:0]     wb_data;
  logic [NB-1:0]     bank_rd_en, bank_wr_en;
  logic [NB*ROWW-1:0] bank_addr;
  logic [DW-1:0]     bank_wr_data;
  logic [NB*DW-1:0]  bank_rd_data;
  logic [NR-1:0]     rsp_valid;
  logic [NR*DW-1:0]  rsp_data;
  logic [15:0]       conflict_cnt;

  always #5 clk = ~clk;
  assign req_reg = {rr[3], rr[2], rr[1], rr[0]};

  gpu_bank_arbiter #(
    .NUM_REQ(NR), .NUM_BANKS(NB), .REG_W(RW), .DATA_W(DW), .BANK_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_reg(req_reg), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .bank_rd_en(bank_rd_en), .bank_wr_en(bank_wr_en), .bank_addr(bank_addr),
    .bank_wr_data(bank_wr_data), .bank_rd_data(bank_rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t        q [NR][$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] mem [NB][64];

  function automatic logic [DW-1:0] init_val(input int unsigned r);
    return {32'hDA7A_0000 | r, ~r};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bank storage: write lands before a later read, 1-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        for (int r = 0; r < 64; r++) mem[b][r] <= init_val(r * NB + b);
      end else begin
        if (bank_wr_en[b]) mem[b][bank_addr[b*ROWW +: ROWW]] <= bank_wr_data;
        if (bank_rd_en[b]) bank_rd_data[b*DW +: DW] <= mem[b][bank_addr[b*ROWW +: ROWW]];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic init_shadow();
    for (int r = 0; r < 256; r++) shadow[r] = init_val(r);
  endtask

  // Check grants in the current cycle, queue expected responses, advance.
  task automatic tick(input logic [NR-1:0] exp_rdy, input bit push);
    @(negedge clk);
    chk("req_ready", req_ready, exp_rdy);
    if (push) begin
      for (int i = 0; i < NR; i++) begin
        if (exp_rdy[i]) q[i].push_back('{data: shadow[rr[i]], cyc: cyc + 3});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NR; i++) begin
          if (rsp_valid[i]) begin
            checks++;
            if (q[i].size() == 0) begin
              errors++;
              $display("FAIL rsp_unexpected[%0d]: got data %h at cycle %0d, required no response",
                       i, rsp_data[i*DW +: DW], cyc);
            end else begin
              e = q[i].pop_front();
              if (rsp_data[i*DW +: DW] !== e.data || cyc != e.cyc) begin
                errors++;
                $display("FAIL rsp[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                         i, rsp_data[i*DW +: DW], cyc, e.data, e.cyc);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_shadow();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) rr[i] = '0;
    wb_valid = 1'b0;
    wb_reg = '0;
    wb_data = '0;
    init_shadow();
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bank_rd_en", bank_rd_en, 0);
    chk("rst_bank_wr_en", bank_wr_en, 0);
    chk("rst_bank_addr", bank_addr, 0);
    chk("rst_bank_wr_data", bank_wr_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data_lo", rsp_data[127:0], 0);
    chk("rst_rsp_data_hi", rsp_data[255:128], 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    rst = 1'b0;

    // Single read: reg 5 -> bank 1, row 1
    rr[0] = 8'd5; req_valid = 4'b0001;
    tick(4'b0001, 1);
    req_valid = '0;
    chk("single_rd_en", bank_rd_en, 4'b0010);
    chk("single_addr_b1", bank_addr[1*ROWW +: ROWW], 1);
    chk("single_wr_en", bank_wr_en, 0);
    repeat (4) tick(4'b0000, 1);
    chk("single_conflict", conflict_cnt, 0);

    // Conflict: all four on bank 2, held
    rr[0] = 8'd2; rr[1] = 8'd6; rr[2] = 8'd10; rr[3] = 8'd14;
    req_valid = 4'b1111;
    tick(4'b0001, 1);
    tick(4'b0010, 1);
    tick(4'b0100, 1);
    tick(4'b1000, 1);
    tick(4'b0001, 1);
    req_valid = '0;
    chk("conflict_cnt5", conflict_cnt, 5);
    repeat (4) tick(4'b0000, 1);

    // Parallel: distinct banks
    rr[0] = 8'd0; rr[1] = 8'd1; rr[2] = 8'd2; rr[3] = 8'd3;
    req_valid = 4'b1111;
    tick(4'b1111, 1);
    req_valid = '0;
    chk("parallel_rd_en", bank_rd_en, 4'b1111);
    repeat (4) tick(4'b0000, 1);
    chk("parallel_conflict", conflict_cnt, 5);

    // Writeback priority on bank 2 (rr_ptr[2] is 3 here)
    wb_valid = 1'b1; wb_reg = 8'd6; wb_data = 64'hCAFE_F00D_1234_5678;
    shadow[6] = 64'hCAFE_F00D_1234_5678;
    rr[1] = 8'd2; rr[3] = 8'd10; req_valid = 4'b1010;
    tick(4'b0000, 1);
    wb_valid = 1'b0;
    chk("wb_wr_en", bank_wr_en, 4'b0100);
    chk("wb_addr_b2", bank_addr[2*ROWW +: ROWW], 1);
    chk("wb_wr_data", bank_wr_data, 64'hCAFE_F00D_1234_5678);
    chk("wb_rd_en", bank_rd_en, 0);
    tick(4'b1000, 1);
    req_valid = 4'b0010;
    chk("wb_next_rd_en", bank_rd_en, 4'b0100);
    chk("wb_next_addr_b2", bank_addr[2*ROWW +: ROWW], 2);
    chk("wb_next_wr_en", bank_wr_en, 0);
    tick(4'b0010, 1);
    req_valid = '0;
    chk("wb_conflict", conflict_cnt, 7);
    rr[0] = 8'd6; req_valid = 4'b0001;
    tick(4'b0001, 1);
    req_valid = '0;
    repeat (4) tick(4'b0000, 1);

    // Reset mid-flight: bank 1 pointer is 2, so requester 2 wins
    rr[0] = 8'd9; rr[2] = 8'd13; req_valid = 4'b0101;
    tick(4'b0100, 0);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", bank_rd_en, 0);
    chk("midrst_addr", bank_addr, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_conflict", conflict_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_shadow();
    req_valid = 4'b0101;
    tick(4'b0001, 1);
    req_valid = 4'b0100;
    tick(4'b0100, 1);
    req_valid = '0;
    repeat (5) tick(4'b0000, 1);
    chk("post_rst_conflict", conflict_cnt, 1);

    // Saturation: writeback blocks a bank-0 read every cycle
    do_reset();
    wb_valid = 1'b1; wb_reg = 8'd0; wb_data = 64'h5A5A_0000_FFFF_0001;
    rr[0] = 8'd4; req_valid = 4'b0001;
    tick(4'b0000, 1);
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_65534", conflict_cnt, 16'd65534);
    @(posedge clk);
    #1;
    chk("sat_ffff", conflict_cnt, 16'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    wb_valid = 1'b0; req_valid = '0;
    shadow[0] = 64'h5A5A_0000_FFFF_0001;
    tick(4'b0000, 1);
    rr[0] = 8'd0; req_valid = 4'b0001;
    tick(4'b0001, 1);
    req_valid = '0;
    repeat (5) tick(4'b0000, 1);
    chk("sat_final", conflict_cnt, 16'hFFFF);

    for (int i = 0; i < NR; i++) chk("rsp_outstanding", q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
